// File: rtl/mips_bus_arbiter.sv
// Two-master (instruction fetch / load-store) arbiter for the shared Avalon-style memory bus.
// Build option: define MIPS_ARB_ROUND_ROBIN_EN for alternating tie-break instead of D priority + starvation counter.
module mips_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] i_address,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [3:0]  i_byteenable,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,

    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,

    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic w_i_pend;
    logic w_d_pend;
    logic w_tie_to_i;
    logic w_pick_i;
    logic w_pick_d;
    logic w_decide;

    // The fetch path never writes, so only i_read makes I pending.
    assign w_i_pend = i_read;
    assign w_d_pend = d_read | d_write;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    logic r_last_grant_d;
    logic w_unused;

    assign w_unused   = i_write ^ (STARVE_LIMIT == 0);
    assign w_tie_to_i = r_last_grant_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_grant_d <= 1'b0;
        end else if (w_decide) begin
            r_last_grant_d <= w_pick_d;
        end
    end
`else
    logic [3:0] r_starve_cnt;
    logic       w_unused;

    assign w_unused   = i_write;
    assign w_tie_to_i = (r_starve_cnt == 4'(STARVE_LIMIT));

    // Counts D wins that left I waiting; clears once I is served or stops asking.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_starve_cnt <= 4'd0;
        end else if (w_decide && w_pick_d && w_i_pend) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end else if (!w_i_pend || (w_decide && w_pick_i)) begin
            r_starve_cnt <= 4'd0;
        end
    end
`endif

    assign w_pick_i = w_i_pend && (!w_d_pend || w_tie_to_i);
    assign w_pick_d = w_d_pend && !w_pick_i;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A decision is taken from IDLE, or on the completing cycle of the current grant.
    always_comb begin
        w_state_next = r_state;
        w_decide     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_decide = w_i_pend | w_d_pend;
            end
            ST_GRANT_I: begin
                if (!w_i_pend) begin
                    w_state_next = ST_IDLE;
                end else if (!mem_waitrequest) begin
                    w_decide = 1'b1;
                end
            end
            ST_GRANT_D: begin
                if (!w_d_pend) begin
                    w_state_next = ST_IDLE;
                end else if (!mem_waitrequest) begin
                    w_decide = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_decide) begin
            w_state_next = w_pick_i ? ST_GRANT_I : ST_GRANT_D;
        end
    end

    always_comb begin
        mem_address    = 32'd0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = 32'd0;
        mem_byteenable = 4'd0;
        i_waitrequest  = 1'b1;
        d_waitrequest  = 1'b1;
        case (r_state)
            ST_GRANT_I: begin
                mem_address    = i_address;
                mem_read       = i_read;
                mem_byteenable = i_byteenable;
                i_waitrequest  = !(w_i_pend && !mem_waitrequest);
            end
            ST_GRANT_D: begin
                mem_address    = d_address;
                mem_write      = d_write;
                mem_read       = d_read & ~d_write;
                mem_writedata  = d_writedata;
                mem_byteenable = d_byteenable;
                d_waitrequest  = !(w_d_pend && !mem_waitrequest);
            end
            default: begin
            end
        endcase
    end

    assign i_readdata = mem_readdata;
    assign d_readdata = mem_readdata;

endmodule
